// File: rtl/lc3b_type.sv
// Shared LC-3b types and branch-target-buffer constants.
//   lc3b_word     : 16-bit machine word / address
//   btb_ctr_t     : 2-bit saturating direction counter (MSB = predict taken)
//   BTB_CTR_INIT  : counter value written when a taken branch is allocated
//   BTB_CTR_RESET : counter value held by every entry after reset
//   btb_ctr_next  : saturating counter step for one resolved outcome
package lc3b_type;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  btb_ctr_t;

    localparam btb_ctr_t BTB_CTR_INIT  = 2'b10;
    localparam btb_ctr_t BTB_CTR_RESET = 2'b01;

    function automatic btb_ctr_t btb_ctr_next(input btb_ctr_t ctr, input logic taken);
        btb_ctr_t nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != 2'b11) nxt = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU helper, purely combinational.
//   i_bits      : current tree bits of one set (node 0 = root, children 2n+1 / 2n+2)
//   i_touch_way : way being touched this cycle
//   o_victim    : way the tree currently points at
//   o_next_bits : tree bits after touching i_touch_way
// A node bit of 0 points at the lower-numbered half. With a single way there
// is no tree: the victim is always way 0 and the bit vector is a dummy.
module plru_tree #(
    parameter int WAYS = 4,
    localparam int PW = (WAYS > 1) ? WAYS - 1 : 1,
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [PW-1:0] i_bits,
    input  logic [WW-1:0] i_touch_way,
    output logic [WW-1:0] o_victim,
    output logic [PW-1:0] o_next_bits
);

    localparam int LVLS = (WAYS > 1) ? $clog2(WAYS) : 1;

    // Walk from the root, following each node bit; the bits taken form the way.
    function automatic logic [WW-1:0] f_victim(input logic [PW-1:0] bits);
        int   way;
        int   base;
        logic b;
        way = 0;
        for (int lvl = 0; lvl < LVLS; lvl++) begin
            base = (1 << lvl) - 1;
            b    = 1'b0;
            for (int n = 0; n < PW; n++) begin
                if (n == base + way) b = bits[n];
            end
            way = 2 * way + int'(b);
        end
        return WW'(way);
    endfunction

    // Walk the touched way's path and make every node on it point away.
    function automatic logic [PW-1:0] f_touch(input logic [PW-1:0] bits,
                                              input logic [WW-1:0] w);
        logic [PW-1:0] nxt;
        int            prefix;
        int            base;
        int            dir;
        nxt    = bits;
        prefix = 0;
        for (int lvl = 0; lvl < LVLS; lvl++) begin
            base = (1 << lvl) - 1;
            dir  = (int'(w) >> (LVLS - 1 - lvl)) & 1;
            for (int n = 0; n < PW; n++) begin
                if (n == base + prefix) nxt[n] = (dir == 0);
            end
            prefix = 2 * prefix + dir;
        end
        return nxt;
    endfunction

    generate
        if (WAYS > 1) begin : g_tree
            always_comb begin
                o_victim    = f_victim(i_bits);
                o_next_bits = f_touch(i_bits, i_touch_way);
            end
        end else begin : g_single
            logic w_unused_single;
            assign w_unused_single = ^{i_bits, i_touch_way};
            assign o_victim        = '0;
            assign o_next_bits     = '0;
        end
    endgenerate

endmodule

// File: rtl/btb_sa.sv
// Set-associative branch target buffer for the LC-3b fetch stage.
//   clk, reset      : single clock, synchronous active-high reset
//   fetch_pc        : lookup address; predict_* answer combinationally
//   predict_hit     : a valid entry matches fetch_pc
//   predict_taken   : hit and counter MSB set
//   predict_target  : stored target on hit, otherwise 0
//   flush           : clear every valid bit on the next edge
//   update_*        : one resolved branch per cycle from the resolve stage
// There is no handshake: when update_valid is high on a rising edge the update
// is applied on that edge (unless reset or flush is also high) and is visible
// to lookups from the next cycle on; same-cycle lookups see the old state.
module btb_sa
    import lc3b_type::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] fetch_pc,
    output logic        predict_hit,
    output logic        predict_taken,
    output logic [15:0] predict_target,
    input  logic        flush,
    input  logic        update_valid,
    input  logic [15:0] update_pc,
    input  logic        update_taken,
    input  logic [15:0] update_target
);

    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = 15 - IDX;
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1;

    logic [WAYS-1:0] r_valid  [SETS];
    logic [TAGW-1:0] r_tag    [SETS][WAYS];
    logic [15:0]     r_target [SETS][WAYS];
    btb_ctr_t        r_ctr    [SETS][WAYS];
    logic [PW-1:0]   r_plru   [SETS];

    // Bit 0 is the byte offset and never takes part in indexing or tagging.
    logic            w_unused_offset;
    assign w_unused_offset = ^{fetch_pc[0], update_pc[0]};

    // ---------------- lookup ----------------
    logic [IDX-1:0]  w_f_idx;
    logic [TAGW-1:0] w_f_tag;
    logic [WAYS-1:0] w_f_match;
    logic [WW-1:0]   w_f_way;

    assign w_f_idx = fetch_pc[IDX:1];
    assign w_f_tag = fetch_pc[15:IDX+1];

    // At most one way can match, so OR-ing the indices is the one-hot encode.
    always_comb begin
        w_f_match = '0;
        w_f_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_f_idx][w] && (r_tag[w_f_idx][w] == w_f_tag)) w_f_match[w] = 1'b1;
        end
        for (int w = 0; w < WAYS; w++) begin
            if (w_f_match[w]) w_f_way = w_f_way | WW'(w);
        end
    end

    assign predict_hit    = |w_f_match;
    assign predict_taken  = predict_hit & r_ctr[w_f_idx][w_f_way][1];
    assign predict_target = predict_hit ? r_target[w_f_idx][w_f_way] : 16'h0000;

    // ---------------- update ----------------
    logic [IDX-1:0]  w_u_idx;
    logic [TAGW-1:0] w_u_tag;
    logic [WAYS-1:0] w_u_match;
    logic            w_u_hit;
    logic [WW-1:0]   w_u_hit_way;
    logic            w_u_has_inv;
    logic [WW-1:0]   w_u_inv_way;
    logic [WW-1:0]   w_victim;
    logic [WW-1:0]   w_u_way;
    logic [PW-1:0]   w_plru_next;
    logic            w_wr_data;

    assign w_u_idx = update_pc[IDX:1];
    assign w_u_tag = update_pc[15:IDX+1];

    always_comb begin
        w_u_match   = '0;
        w_u_hit_way = '0;
        w_u_has_inv = 1'b0;
        w_u_inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_u_idx][w] && (r_tag[w_u_idx][w] == w_u_tag)) w_u_match[w] = 1'b1;
        end
        for (int w = 0; w < WAYS; w++) begin
            if (w_u_match[w]) w_u_hit_way = w_u_hit_way | WW'(w);
        end
        // Scan downward so the lowest-numbered invalid way is the one left.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_u_idx][w]) begin
                w_u_has_inv = 1'b1;
                w_u_inv_way = WW'(w);
            end
        end
    end

    assign w_u_hit = |w_u_match;
    assign w_u_way = w_u_hit ? w_u_hit_way : (w_u_has_inv ? w_u_inv_way : w_victim);

    plru_tree #(.WAYS(WAYS)) u_plru (
        .i_bits      (r_plru[w_u_idx]),
        .i_touch_way (w_u_way),
        .o_victim    (w_victim),
        .o_next_bits (w_plru_next)
    );

    // Control state: reset > flush > update. Flush keeps counters and PLRU.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
                for (int w = 0; w < WAYS; w++) r_ctr[s][w] <= BTB_CTR_RESET;
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
        end else if (update_valid) begin
            if (w_u_hit) begin
                r_ctr[w_u_idx][w_u_way] <= btb_ctr_next(r_ctr[w_u_idx][w_u_way], update_taken);
                r_plru[w_u_idx]         <= w_plru_next;
            end else if (update_taken) begin
                r_valid[w_u_idx][w_u_way] <= 1'b1;
                r_ctr[w_u_idx][w_u_way]   <= BTB_CTR_INIT;
                r_plru[w_u_idx]           <= w_plru_next;
            end
        end
    end

    // Tag and target storage needs no reset: nothing reads it while invalid.
    // Every taken update either refreshes a hit's target or allocates.
    assign w_wr_data = !reset && !flush && update_valid && update_taken;

    always_ff @(posedge clk) begin
        if (w_wr_data) begin
            if (!w_u_hit) r_tag[w_u_idx][w_u_way] <= w_u_tag;
            r_target[w_u_idx][w_u_way] <= update_target;
        end
    end

endmodule

// File: tb/tb_btb_sa.sv
module tb_btb_sa;

    // ---------------- clock / reset / stimulus signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        flush;
    logic        update_valid;
    logic        update_taken;
    logic [15:0] fetch_pc;
    logic [15:0] update_pc;
    logic [15:0] update_target;

    logic [3:0]       hit_v;
    logic [3:0]       taken_v;
    logic [3:0][15:0] tgt_p;

    int n_total = 0;
    int n_bad   = 0;

    // Instance 0 is the default configuration used by the directed tests;
    // the others form the parameter sweep and see the same input stream.
    int cfg_ways [4] = '{4, 1, 2, 8};
    int cfg_sets [4] = '{64, 2, 128, 2};
    int cfg_lg   [4] = '{6, 1, 7, 1};

    btb_sa #(.WAYS(4), .SETS(64)) dut (
        .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
        .predict_hit(hit_v[0]), .predict_taken(taken_v[0]), .predict_target(tgt_p[0]),
        .flush(flush), .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_target(update_target)
    );
    btb_sa #(.WAYS(1), .SETS(2)) dut_w1 (
        .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
        .predict_hit(hit_v[1]), .predict_taken(taken_v[1]), .predict_target(tgt_p[1]),
        .flush(flush), .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_target(update_target)
    );
    btb_sa #(.WAYS(2), .SETS(128)) dut_w2 (
        .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
        .predict_hit(hit_v[2]), .predict_taken(taken_v[2]), .predict_target(tgt_p[2]),
        .flush(flush), .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_target(update_target)
    );
    btb_sa #(.WAYS(8), .SETS(2)) dut_w8 (
        .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
        .predict_hit(hit_v[3]), .predict_taken(taken_v[3]), .predict_target(tgt_p[3]),
        .flush(flush), .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_target(update_target)
    );

    // ---------------- reference model ----------------
    bit          m_valid [4][128][8];
    int          m_tag   [4][128][8];
    logic [15:0] m_tgt   [4][128][8];
    int          m_ctr   [4][128][8];
    bit          m_plru  [4][128][8];

    function automatic int m_idx(input int k, input logic [15:0] pc);
        return (int'(pc) >> 1) % cfg_sets[k];
    endfunction

    function automatic int m_tag_of(input int k, input logic [15:0] pc);
        return int'(pc) >> (cfg_lg[k] + 1);
    endfunction

    function automatic int m_find(input int k, input logic [15:0] pc);
        int s;
        s = m_idx(k, pc);
        for (int w = 0; w < cfg_ways[k]; w++)
            if (m_valid[k][s][w] && m_tag[k][s][w] == m_tag_of(k, pc)) return w;
        return -1;
    endfunction

    // Range halving: node bit 0 sends the search into the lower half.
    function automatic int m_victim(input int k, input int s);
        int lo, span, half, node;
        lo = 0; span = cfg_ways[k]; node = 0;
        while (span > 1) begin
            half = span / 2;
            if (!m_plru[k][s][node]) node = 2 * node + 1;
            else begin lo += half; node = 2 * node + 2; end
            span = half;
        end
        return lo;
    endfunction

    task automatic m_touch(input int k, input int s, input int w);
        int lo, span, half, node;
        lo = 0; span = cfg_ways[k]; node = 0;
        while (span > 1) begin
            half = span / 2;
            if (w < lo + half) begin m_plru[k][s][node] = 1'b1; node = 2 * node + 1; end
            else begin m_plru[k][s][node] = 1'b0; lo += half; node = 2 * node + 2; end
            span = half;
        end
    endtask

    task automatic m_step();
        int s, w;
        for (int k = 0; k < 4; k++) begin
            if (reset) begin
                for (int a = 0; a < 128; a++)
                    for (int b = 0; b < 8; b++) begin
                        m_valid[k][a][b] = 1'b0; m_plru[k][a][b] = 1'b0; m_ctr[k][a][b] = 1;
                    end
            end else if (flush) begin
                for (int a = 0; a < 128; a++)
                    for (int b = 0; b < 8; b++) m_valid[k][a][b] = 1'b0;
            end else if (update_valid) begin
                s = m_idx(k, update_pc);
                w = m_find(k, update_pc);
                if (w >= 0) begin
                    if (update_taken) begin
                        m_ctr[k][s][w] = (m_ctr[k][s][w] < 3) ? m_ctr[k][s][w] + 1 : 3;
                        m_tgt[k][s][w] = update_target;
                    end else begin
                        m_ctr[k][s][w] = (m_ctr[k][s][w] > 0) ? m_ctr[k][s][w] - 1 : 0;
                    end
                    m_touch(k, s, w);
                end else if (update_taken) begin
                    w = -1;
                    for (int b = cfg_ways[k] - 1; b >= 0; b--) if (!m_valid[k][s][b]) w = b;
                    if (w < 0) w = m_victim(k, s);
                    m_valid[k][s][w] = 1'b1;
                    m_tag[k][s][w]   = m_tag_of(k, update_pc);
                    m_tgt[k][s][w]   = update_target;
                    m_ctr[k][s][w]   = 2;
                    m_touch(k, s, w);
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Every clock edge goes through here so the model steps with the DUTs.
    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic upd(input logic [15:0] pc, input logic taken, input logic [15:0] tgt);
        update_valid  = 1'b1;
        update_pc     = pc;
        update_taken  = taken;
        update_target = tgt;
        tick();
        update_valid  = 1'b0;
    endtask

    task automatic look(input logic [15:0] pc);
        fetch_pc = pc;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; update_valid = 1'b0; update_taken = 1'b0;
        update_pc = 16'h0; update_target = 16'h0; fetch_pc = 16'h0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        look(16'h3000);
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if ({hit_v[k], taken_v[k], tgt_p[k]} !== {1'b0, 1'b0, 16'h0000}) begin
                n_bad++;
                $display("FAIL reset k=%0d: hit=%0b taken=%0b tgt=%h want 0 0 0000", k, hit_v[k], taken_v[k], tgt_p[k]);
            end
        end
    endtask

    task automatic test_alloc_train();
        upd(16'h3002, 1'b1, 16'h3040);
        look(16'h3002);
        n_total++;
        if ({hit_v[0], taken_v[0], tgt_p[0]} !== {1'b1, 1'b1, 16'h3040}) begin
            n_bad++;
            $display("FAIL alloc: hit=%0b taken=%0b tgt=%h want 1 1 3040", hit_v[0], taken_v[0], tgt_p[0]);
        end
        upd(16'h3002, 1'b0, 16'h1111);
        upd(16'h3002, 1'b0, 16'h2222);
        look(16'h3002);
        n_total++;
        if ({hit_v[0], taken_v[0], tgt_p[0]} !== {1'b1, 1'b0, 16'h3040}) begin
            n_bad++;
            $display("FAIL train_nt: hit=%0b taken=%0b tgt=%h want 1 0 3040", hit_v[0], taken_v[0], tgt_p[0]);
        end
        upd(16'h3002, 1'b1, 16'h3050);
        upd(16'h3002, 1'b1, 16'h3060);
        look(16'h3002);
        n_total++;
        if ({hit_v[0], taken_v[0], tgt_p[0]} !== {1'b1, 1'b1, 16'h3060}) begin
            n_bad++;
            $display("FAIL train_t: hit=%0b taken=%0b tgt=%h want 1 1 3060", hit_v[0], taken_v[0], tgt_p[0]);
        end
        // Drive into 11, push once more, then one not-taken must leave 10.
        upd(16'h3002, 1'b1, 16'h3070);
        upd(16'h3002, 1'b1, 16'h3080);
        upd(16'h3002, 1'b0, 16'h0000);
        look(16'h3002);
        n_total++;
        if ({hit_v[0], taken_v[0], tgt_p[0]} !== {1'b1, 1'b1, 16'h3080}) begin
            n_bad++;
            $display("FAIL saturate_hi: hit=%0b taken=%0b tgt=%h want 1 1 3080", hit_v[0], taken_v[0], tgt_p[0]);
        end
        upd(16'h3002, 1'b0, 16'h0000);
        look(16'h3002);
        n_total++;
        if ({hit_v[0], taken_v[0], tgt_p[0]} !== {1'b1, 1'b0, 16'h3080}) begin
            n_bad++;
            $display("FAIL weak_nt: hit=%0b taken=%0b tgt=%h want 1 0 3080", hit_v[0], taken_v[0], tgt_p[0]);
        end
    endtask

    task automatic test_miss_not_taken();
        upd(16'h3004, 1'b0, 16'h5555);
        look(16'h3004);
        n_total++;
        if ({hit_v[0], taken_v[0], tgt_p[0]} !== {1'b0, 1'b0, 16'h0000}) begin
            n_bad++;
            $display("FAIL miss_nt: hit=%0b taken=%0b tgt=%h want 0 0 0000", hit_v[0], taken_v[0], tgt_p[0]);
        end
    endtask

    task automatic test_replacement();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        upd(16'h0002, 1'b1, 16'hA000);
        upd(16'h0082, 1'b1, 16'hA001);
        upd(16'h0102, 1'b1, 16'hA002);
        upd(16'h0182, 1'b1, 16'hA003);
        upd(16'h0002, 1'b1, 16'hA000);
        upd(16'h0202, 1'b1, 16'hA004);
        look(16'h0102);
        n_total++;
        if (hit_v[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL evict_way2: hit=%0b want 0", hit_v[0]);
        end
        look(16'h0002);
        n_total++;
        if ({hit_v[0], taken_v[0], tgt_p[0]} !== {1'b1, 1'b1, 16'hA000}) begin
            n_bad++;
            $display("FAIL keep_way0: hit=%0b taken=%0b tgt=%h want 1 1 a000", hit_v[0], taken_v[0], tgt_p[0]);
        end
        look(16'h0202);
        n_total++;
        if ({hit_v[0], taken_v[0], tgt_p[0]} !== {1'b1, 1'b1, 16'hA004}) begin
            n_bad++;
            $display("FAIL new_alloc: hit=%0b taken=%0b tgt=%h want 1 1 a004", hit_v[0], taken_v[0], tgt_p[0]);
        end
        look(16'h3002);
        n_total++;
        if (hit_v[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL flushed_entry: hit=%0b want 0", hit_v[0]);
        end
    endtask

    task automatic test_same_cycle();
        update_valid = 1'b1; update_pc = 16'h3010; update_taken = 1'b1; update_target = 16'h4010;
        fetch_pc = 16'h3010;
        #1;
        n_total++;
        if (hit_v[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL same_cycle_pre: hit=%0b want 0", hit_v[0]);
        end
        tick();
        update_valid = 1'b0;
        #1;
        n_total++;
        if ({hit_v[0], taken_v[0], tgt_p[0]} !== {1'b1, 1'b1, 16'h4010}) begin
            n_bad++;
            $display("FAIL same_cycle_post: hit=%0b taken=%0b tgt=%h want 1 1 4010", hit_v[0], taken_v[0], tgt_p[0]);
        end
    endtask

    task automatic test_flush_update();
        flush = 1'b1;
        upd(16'h3020, 1'b1, 16'h4020);
        flush = 1'b0;
        look(16'h3020);
        n_total++;
        if (hit_v[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_drops_update: hit=%0b want 0", hit_v[0]);
        end
        look(16'h3010);
        n_total++;
        if (hit_v[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_clears: hit=%0b want 0", hit_v[0]);
        end
    endtask

    task automatic test_back_to_back();
        upd(16'h3030, 1'b1, 16'hB000);
        upd(16'h3030, 1'b1, 16'hB001);
        upd(16'h3030, 1'b0, 16'h0000);
        upd(16'h3030, 1'b0, 16'h0000);
        look(16'h3030);
        n_total++;
        if ({hit_v[0], taken_v[0], tgt_p[0]} !== {1'b1, 1'b0, 16'hB001}) begin
            n_bad++;
            $display("FAIL back_to_back: hit=%0b taken=%0b tgt=%h want 1 0 b001", hit_v[0], taken_v[0], tgt_p[0]);
        end
    endtask

    task automatic test_reset_during_update();
        reset = 1'b1;
        upd(16'h3040, 1'b1, 16'h4040);
        reset = 1'b0;
        tick();
        look(16'h3040);
        n_total++;
        if (hit_v[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_wins: hit=%0b want 0", hit_v[0]);
        end
        look(16'h3030);
        n_total++;
        if (hit_v[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_clears: hit=%0b want 0", hit_v[0]);
        end
    endtask

    task automatic test_random();
        int          w;
        logic        eh, et;
        logic [15:0] etg;
        for (int c = 0; c < 1500; c++) begin
            reset         = ($urandom_range(0, 299) == 0);
            flush         = ($urandom_range(0, 49) == 0);
            update_valid  = ($urandom_range(0, 1) == 1);
            update_taken  = ($urandom_range(0, 9) < 7);
            update_pc     = 16'(($urandom_range(0, 15) << 8) | ($urandom_range(0, 3) << 1) | $urandom_range(0, 1));
            update_target = 16'($urandom_range(0, 65535));
            fetch_pc      = 16'(($urandom_range(0, 15) << 8) | ($urandom_range(0, 3) << 1) | $urandom_range(0, 1));
            #1;
            for (int k = 0; k < 4; k++) begin
                w   = m_find(k, fetch_pc);
                eh  = (w >= 0);
                et  = eh && (m_ctr[k][m_idx(k, fetch_pc)][w] >= 2);
                etg = eh ? m_tgt[k][m_idx(k, fetch_pc)][w] : 16'h0000;
                n_total++;
                if ({hit_v[k], taken_v[k], tgt_p[k]} !== {eh, et, etg}) begin
                    n_bad++;
                    $display("FAIL random k=%0d cyc=%0d pc=%h: hit=%0b taken=%0b tgt=%h want %0b %0b %h",
                             k, c, fetch_pc, hit_v[k], taken_v[k], tgt_p[k], eh, et, etg);
                end
            end
            tick();
        end
        reset = 1'b0; flush = 1'b0; update_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alloc_train();
        test_miss_not_taken();
        test_replacement();
        test_same_cycle();
        test_flush_update();
        test_back_to_back();
        test_reset_during_update();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
